// File: rtl/dds_tone_core.sv
// Sandpiper DDS tone core: debounced up/down buttons set a divider, an NCO walks the sine LUT
// address, and a first-order delta-sigma modulator renders the returned sample. Optional: DDS_AUTOREPEAT_EN.
module dds_tone_core #(
    parameter int unsigned      SYSCLK_FREQ     = 50000000,
    parameter int unsigned      DEBOUNCE_CYCLES = SYSCLK_FREQ / 100,
    parameter int unsigned      DIV_W           = 16,
    parameter int unsigned      ADDR_W          = 8,
    parameter int unsigned      DATA_W          = 16,
    parameter logic [DIV_W-1:0] DIV_INIT        = '0
`ifdef DDS_AUTOREPEAT_EN
    ,
    parameter int unsigned      REPEAT_CYCLES   = SYSCLK_FREQ / 10
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              btn_up,
    input  logic              btn_dn,
    input  logic [DATA_W-1:0] sample_in,
    output logic [ADDR_W-1:0] lut_addr,
    output logic [DIV_W-1:0]  divider,
    output logic              btn_up_q,
    output logic              btn_dn_q,
    output logic              mod_out
);

    localparam int unsigned     DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 is the up button, bit 1 the down button, throughout.
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            db_q, db_d;
    logic [1:0]            db_prev_q, db_prev_d;
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [1:0]            rise;
    logic                  step_up, step_dn;

    logic [DIV_W-1:0]      divider_q, divider_d;
    logic [DIV_W-1:0]      nco_cnt_q, nco_cnt_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;

    logic [DATA_W:0]       acc_sum;
    logic [DATA_W-1:0]     acc_q, acc_d;
    logic                  mod_q, mod_d;

`ifdef DDS_AUTOREPEAT_EN
    localparam int unsigned      RPT_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0]      rpt_cnt_q, rpt_cnt_d;
`endif

    always_comb begin
        sync1_d   = {btn_dn, btn_up};
        sync2_d   = sync1_q;
        db_prev_d = db_q;
        db_d      = db_q;
        db_cnt_d  = '0;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != db_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    db_d[b] = sync2_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
                end
            end
        end

        // A press only counts while the other button is released.
        rise    = db_q & ~db_prev_q;
        step_up = rise[0] & ~db_q[1];
        step_dn = rise[1] & ~db_q[0];

`ifdef DDS_AUTOREPEAT_EN
        // The repeat timer restarts on every press edge and only runs while one button is held.
        rpt_cnt_d = '0;
        if ((db_q[0] ^ db_q[1]) && (rise == 2'b00)) begin
            if (rpt_cnt_q == RPT_LAST) begin
                step_up = step_up | db_q[0];
                step_dn = step_dn | db_q[1];
            end else begin
                rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
        end
`endif

        divider_d = divider_q;
        if (step_up && (divider_q != '1)) begin
            divider_d = divider_q + DIV_W'(1);
        end else if (step_dn && (divider_q != '0)) begin
            divider_d = divider_q - DIV_W'(1);
        end

        // >= so a divider lowered below the running count wraps on the next enabled cycle.
        nco_cnt_d = nco_cnt_q;
        addr_d    = addr_q;
        if (en) begin
            if (nco_cnt_q >= divider_q) begin
                nco_cnt_d = '0;
                addr_d    = addr_q + ADDR_W'(1);
            end else begin
                nco_cnt_d = nco_cnt_q + DIV_W'(1);
            end
        end

        // The carry out is the modulator output; only the low DATA_W bits are kept.
        acc_sum = {1'b0, acc_q} + {1'b0, sample_in};
        acc_d   = acc_sum[DATA_W-1:0];
        mod_d   = acc_sum[DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            db_cnt_q  <= '0;
            divider_q <= DIV_INIT;
            nco_cnt_q <= '0;
            addr_q    <= '0;
            acc_q     <= '0;
            mod_q     <= 1'b0;
`ifdef DDS_AUTOREPEAT_EN
            rpt_cnt_q <= '0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            db_cnt_q  <= db_cnt_d;
            divider_q <= divider_d;
            nco_cnt_q <= nco_cnt_d;
            addr_q    <= addr_d;
            acc_q     <= acc_d;
            mod_q     <= mod_d;
`ifdef DDS_AUTOREPEAT_EN
            rpt_cnt_q <= rpt_cnt_d;
`endif
        end
    end

    assign lut_addr = addr_q;
    assign divider  = divider_q;
    assign btn_up_q = db_q[0];
    assign btn_dn_q = db_q[1];
    assign mod_out  = mod_q;

endmodule

// File: tb/tb_dds_tone_core.sv
// Self-checking bench for dds_tone_core: button/divider behaviour, NCO rate and modulator density,
// with a second instance started near full scale to exercise saturation.
module tb_dds_tone_core;

    logic        clk;
    logic        rst;
    logic        en;
    logic        btn_up;
    logic        btn_dn;
    logic [15:0] sample_in;

    logic [7:0]  lut_addr, s_lut_addr;
    logic [15:0] divider, s_divider;
    logic        up_q, dn_q, s_up_q, s_dn_q;
    logic        mod_out, s_mod_out;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          smode    = 0;
    bit          mod_chk  = 1'b0;

    // Modulator reference: ones emitted so far equal floor(sum of samples / 2^16).
    longint      mod_sum  = 0;
    longint      mod_old  = 0;
    logic        exp_mod  = 1'b0;

    int          exp_div;
    int          exp_sdiv;

`ifdef DDS_AUTOREPEAT_EN
    localparam int HOLD_STEPS = 4;
`else
    localparam int HOLD_STEPS = 1;
`endif

    dds_tone_core #(
        .DEBOUNCE_CYCLES(4),
        .DIV_INIT       (16'd3)
`ifdef DDS_AUTOREPEAT_EN
        ,
        .REPEAT_CYCLES  (10)
`endif
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .btn_up   (btn_up),
        .btn_dn   (btn_dn),
        .sample_in(sample_in),
        .lut_addr (lut_addr),
        .divider  (divider),
        .btn_up_q (up_q),
        .btn_dn_q (dn_q),
        .mod_out  (mod_out)
    );

    dds_tone_core #(
        .DEBOUNCE_CYCLES(4),
        .DIV_INIT       (16'hFFFE)
`ifdef DDS_AUTOREPEAT_EN
        ,
        .REPEAT_CYCLES  (10)
`endif
    ) u_dut_sat (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .btn_up   (btn_up),
        .btn_dn   (btn_dn),
        .sample_in(sample_in),
        .lut_addr (s_lut_addr),
        .divider  (s_divider),
        .btn_up_q (s_up_q),
        .btn_dn_q (s_dn_q),
        .mod_out  (s_mod_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int step(input int cur, input bit up, input bit dn, input int maxv);
        if (up && !dn) return (cur == maxv) ? cur : cur + 1;
        if (dn && !up) return (cur == 0) ? 0 : cur - 1;
        return cur;
    endfunction

    task automatic check_divs(input string tag);
        check_eq({tag, "_div"}, 32'(divider), 32'(exp_div));
        check_eq({tag, "_sdiv"}, 32'(s_divider), 32'(exp_sdiv));
    endtask

    task automatic do_reset();
        @(negedge clk);
        en     = 1'b0;
        btn_up = 1'b0;
        btn_dn = 1'b0;
        rst    = 1'b1;
        cycles(2);
        exp_div  = 3;
        exp_sdiv = 16'hFFFE;
        check_divs("reset");
        check_eq("reset_addr", 32'(lut_addr), 0);
        check_eq("reset_mod", 32'(mod_out), 0);
        check_eq("reset_up_q", 32'(up_q), 0);
        check_eq("reset_dn_q", 32'(dn_q), 0);
        rst = 1'b0;
    endtask

    task automatic press(input bit up, input bit dn, input string tag);
        btn_up = up;
        btn_dn = dn;
        cycles(8);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        cycles(25);
        exp_div  = step(exp_div, up, dn, 16'hFFFF);
        exp_sdiv = step(exp_sdiv, up, dn, 16'hFFFF);
        check_divs(tag);
    endtask

    task automatic run_nco(input int len, input int div, input string tag);
        int n = 0;
        for (int i = 0; i < len; i++) begin
            en = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            if (en) n++;
            @(negedge clk);
            check_eq(tag, 32'(lut_addr), 32'((n / (div + 1)) % 256));
        end
        en = 1'b0;
    endtask

    // Sample stimulus, changed just after each rising edge.
    initial begin
        sample_in = 16'h8000;
        forever begin
            @(posedge clk);
            #1;
            case (smode)
                0:       sample_in = 16'h8000;
                1:       sample_in = 16'h4000;
                2:       sample_in = 16'h0000;
                3:       sample_in = 16'hFFFF;
                default: sample_in = 16'($urandom);
            endcase
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mod_sum = 0;
                exp_mod = 1'b0;
            end else begin
                mod_old = mod_sum;
                mod_sum = mod_sum + longint'(sample_in);
                exp_mod = ((mod_sum >> 16) != (mod_old >> 16));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mod_chk) begin
                check_eq("mod_out", 32'(mod_out), 32'(exp_mod));
                check_eq("s_mod_out", 32'(s_mod_out), 32'(exp_mod));
            end
        end
    end

    initial begin
        bit seen;
        int waited;
        rst    = 1'b1;
        en     = 1'b0;
        btn_up = 1'b0;
        btn_dn = 1'b0;
        do_reset();
        mod_chk = 1'b1;

        // Clean press: debounced level appears 2 + DEBOUNCE_CYCLES edges after the first sample.
        btn_up = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 5) check_eq("db_lat_low", 32'(up_q), 0);
            if (i == 6) check_eq("db_lat_high", 32'(up_q), 1);
        end
        exp_div  = 4;
        exp_sdiv = 16'hFFFF;
        check_divs("first_up");
        btn_up = 1'b0;
        cycles(25);
        check_eq("db_release", 32'(up_q), 0);
        check_divs("first_up_after");

        smode = 1;
        btn_up = 1'b1;
        cycles(3);
        btn_up = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (up_q) seen = 1'b1;
        end
        check_eq("glitch_q", 32'(seen), 0);
        check_divs("glitch");

        smode = 2;
        press(1'b1, 1'b0, "up_sat");
        press(1'b1, 1'b1, "both");
        smode = 3;
        for (int i = 0; i < 6; i++) press(1'b0, 1'b1, "down");

        // Down held, up pressed while it is held: only the down press steps.
        smode = 4;
        for (int i = 0; i < 10; i++) begin
            btn_dn = 1'b1;
            btn_up = (i >= 3) && (i < 9);
            @(negedge clk);
        end
        btn_up = 1'b0;
        btn_dn = 1'b0;
        cycles(25);
        exp_div  = step(exp_div, 1'b0, 1'b1, 16'hFFFF);
        exp_sdiv = step(exp_sdiv, 1'b0, 1'b1, 16'hFFFF);
        check_divs("overlap");

        run_nco(600, 0, "nco_div0");

        do_reset();
        run_nco(500, 3, "nco_div3");

        btn_up = 1'b1;
        waited = 0;
        while (!up_q && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_eq("rpt_q_rise", 32'(up_q), 1);
        cycles(35);
        exp_div  = 3 + HOLD_STEPS;
        exp_sdiv = 16'hFFFF;
        check_divs("hold");
        btn_up = 1'b0;
        cycles(30);
        check_eq("hold_release", 32'(up_q), 0);

        mod_chk = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
